serial_link_host: RTL and testbench
===================================

Name: serial_link_host

Overview:
Host-side link controller that drives the 12-bit serial interface of the cache chip wrapper. It runs on the same fast clock as the chip and keeps a phase counter in lockstep with it.
- Accepts parallel CPU request frames through a valid/ready FIFO and serializes them over phases 0-3.
- Samples memory-side handshake bits and inserts them in phase 3.
- Reassembles the 24-bit output word sent in phases 4-5 into a decoded response with a valid pulse.

Parameters:
FIFO_DEPTH, 2, request FIFO entries (power of two, >=2)
CNT_W, 16, frame counter width

Ports:
clk  in  1  fast system clock, shared with chip wrapper
reset_n  in  1  async active-low reset, shared with chip wrapper
req_valid  in  1  request frame offered
req_ready  out  1  FIFO can accept (registered count < FIFO_DEPTH)
req_cpu_valid  in  4  per-core valid
req_cpu_command  in  4  per-core command
req_cpu_addr  in  24  {addr3,addr2,addr1,addr0}, 6 bits each
req_cpu_wr_data  in  4  per-core write data
mem_req_ready  in  1  from memory model
mem_resp_valid  in  1  from memory model
mem_resp_data  in  1  from memory model
in_bits  out  12  serial data to chip
out_bits  in  12  serial data from chip
rsp_valid  out  1  one-cycle pulse, response word complete
rsp_cpu_ready  out  4
rsp_cpu_read_valid  out  4
rsp_cpu_read_data  out  4
rsp_mem_req_valid  out  1
rsp_mem_req_rw  out  1
rsp_mem_req_addr  out  6
rsp_mem_req_data  out  1
pad_err  out  1  sticky: nonzero padding bits 23:21 seen
frame_cnt  out  CNT_W  completed frames, wraps
phase  out  3  current phase 0-5

Behaviour:
- Reset is asynchronous, active-low, single clock clk.
- Reset values: phase=0, FIFO empty, frame register=0, handshake register=0, in_bits=0, all rsp_* = 0, rsp_valid=0, pad_err=0, frame_cnt=0. Reset mid-frame aborts the frame with no response.
- Phase counter: 0..5, 5 wraps to 0, increments every clk.
- Frame load: on the posedge where phase==5, the frame register loads the FIFO head (pop) if the FIFO is non-empty. Otherwise it loads the idle frame (all zeros).
- Handshake load: on the posedge where phase==2, register {mem_req_ready, mem_resp_valid, mem_resp_data}.
- in_bits, combinational from phase plus registers:
  - phase 0: {cpu_valid, cpu_command, cpu_wr_data}
  - phase 1: addr[11:0]
  - phase 2: addr[23:12]
  - phase 3: {9'b0, handshake[2:0]}
  - phases 4, 5: 12'h000
- Response capture:
  - Posedge at phase==4: low half <= out_bits.
  - Posedge at phase==5: high half <= out_bits; rsp_* fields update from the combined word; rsp_valid=1 for the following cycle (phase 0) only.
- Response word layout: [20:17] cpu_ready, [16:13] read_valid, [12:9] read_data, [8] mem_req_valid, [7] rw, [6:1] addr, [0] data. rsp_* hold until the next capture.
- pad_err: set when word[23:21] != 0 at capture; cleared only by reset.
- frame_cnt: increments at the same edge rsp_valid is set; wraps at 2^CNT_W. Idle frames count.
- Latency: a request accepted on a cycle whose posedge is a phase-5 edge is not loaded (no bypass) and misses that frame. A request accepted in phase 0 of frame N loads at the end of that frame, phases 0-3 of frame N+1 carry it, and its response is rsp_valid at phase 0 of frame N+2.
- FIFO push and pop in the same cycle are both allowed. req_ready depends on the registered count only, so a pop never opens ready in the same cycle.
- Full FIFO: req_ready=0; req_valid while not ready is ignored.

Decomposition:
- Package link_pkg:
  - phase constants PH_CAP0..PH_OUT_HI (0..5), NUM_PHASES=6
  - typedef link_req_t {cpu_valid, cpu_command, cpu_addr, cpu_wr_data}, 36 bits
  - typedef link_rsp_t packed to the 24-bit layout above, PAD_W=3
- Sub-module: link_req_fifo (sync FIFO of link_req_t, FIFO_DEPTH, count-based full/empty, same clk/reset_n).

Test Plan:
- Reset, no requests -> in_bits=0 in every phase; rsp_valid pulses every 6 cycles in phase 0; frame_cnt 1,2,3...
- One request: valid=4'b0001, cmd=4'b0001, addr=24'hABC123, wr=4'b0001, accepted in phase 0 -> next frame in_bits = 12'h111, 12'h123, 12'hABC, then handshake.
- mem_req_ready=1, resp_valid=0, resp_data=1 held through phase 2 -> in_bits=12'h005 in phase 3.
- out_bits=12'h5A3 in phase 4 and 12'h0F1 in phase 5 -> word 24'h0F15A3; rsp_cpu_ready=4'h7, read_valid=4'h8, read_data=4'hA, mem_req_valid=1, rw=1, addr=6'h11, data=1; pad_err=0. A later high half of 12'hE00 -> pad_err=1 and stays set.
- Push 3 back-to-back requests with FIFO_DEPTH=2 -> req_ready drops after 2; the third is accepted after the phase-5 pop; frames go out in order.
- Assert reset_n low during phase 2 with FIFO holding 2 entries -> in_bits=0 immediately, FIFO empty, no rsp_valid, phase restarts at 0.

Source files
------------

// File: rtl/serial_link_host_pkg.sv
// Shared types and phase numbering for the host side of the 6-phase serial link.
package link_pkg;
  localparam int NUM_PHASES = 6;
  localparam int PAD_W      = 3;

  localparam logic [2:0] PH_CAP0   = 3'd0;
  localparam logic [2:0] PH_CAP1   = 3'd1;
  localparam logic [2:0] PH_CAP2   = 3'd2;
  localparam logic [2:0] PH_HSK    = 3'd3;
  localparam logic [2:0] PH_OUT_LO = 3'd4;
  localparam logic [2:0] PH_OUT_HI = 3'd5;

  typedef struct packed {
    logic [3:0]  cpu_valid;
    logic [3:0]  cpu_command;
    logic [23:0] cpu_addr;
    logic [3:0]  cpu_wr_data;
  } link_req_t;

  typedef struct packed {
    logic [PAD_W-1:0] pad;
    logic [3:0]       cpu_ready;
    logic [3:0]       read_valid;
    logic [3:0]       read_data;
    logic             mem_req_valid;
    logic             mem_req_rw;
    logic [5:0]       mem_req_addr;
    logic             mem_req_data;
  } link_rsp_t;
endpackage

// File: rtl/serial_link_host_if.sv
// Bundle of CPU request, memory handshake, serial and decoded response signals.
interface serial_link_host_if #(parameter int CNT_W = 16);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cpu_valid;
  logic [3:0]       req_cpu_command;
  logic [23:0]      req_cpu_addr;
  logic [3:0]       req_cpu_wr_data;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic             mem_resp_data;
  logic [11:0]      in_bits;
  logic [11:0]      out_bits;
  logic             rsp_valid;
  logic [3:0]       rsp_cpu_ready;
  logic [3:0]       rsp_cpu_read_valid;
  logic [3:0]       rsp_cpu_read_data;
  logic             rsp_mem_req_valid;
  logic             rsp_mem_req_rw;
  logic [5:0]       rsp_mem_req_addr;
  logic             rsp_mem_req_data;
  logic             pad_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [2:0]       phase;

  modport master (
    output req_valid, req_cpu_valid, req_cpu_command, req_cpu_addr, req_cpu_wr_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data, out_bits,
    input  req_ready, in_bits, rsp_valid, rsp_cpu_ready, rsp_cpu_read_valid,
    input  rsp_cpu_read_data, rsp_mem_req_valid, rsp_mem_req_rw, rsp_mem_req_addr,
    input  rsp_mem_req_data, pad_err, frame_cnt, phase
  );

  modport slave (
    input  req_valid, req_cpu_valid, req_cpu_command, req_cpu_addr, req_cpu_wr_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, out_bits,
    output req_ready, in_bits, rsp_valid, rsp_cpu_ready, rsp_cpu_read_valid,
    output rsp_cpu_read_data, rsp_mem_req_valid, rsp_mem_req_rw, rsp_mem_req_addr,
    output rsp_mem_req_data, pad_err, frame_cnt, phase
  );
endinterface

// File: rtl/link_req_fifo.sv
// Count-based synchronous FIFO of request frames; full/empty come from the registered count.
module link_req_fifo
  import link_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push_i,
  input  link_req_t push_data_i,
  input  logic      pop_i,
  output link_req_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  link_req_t   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/serial_link_host.sv
// Host link controller: serializes queued CPU frames in phases 0-3 and rebuilds
// the chip's 24-bit response word from phases 4-5.
module serial_link_host
  import link_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               reset_n,
  serial_link_host_if.slave bus
);
  logic [2:0]       phase_q, phase_d;
  link_req_t        frame_q, head, req_in;
  logic [2:0]       hs_q;
  logic [11:0]      lo_q;
  link_rsp_t        rsp_q, rsp_word;
  logic             rsp_valid_q, pad_err_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             full, empty, push, pop;
  logic [11:0]      in_bits_c;

  assign req_in   = {bus.req_cpu_valid, bus.req_cpu_command, bus.req_cpu_addr, bus.req_cpu_wr_data};
  assign push     = bus.req_valid && !full;
  assign pop      = (phase_q == PH_OUT_HI) && !empty;
  assign phase_d  = (phase_q == PH_OUT_HI) ? PH_CAP0 : phase_q + 3'd1;
  assign rsp_word = link_rsp_t'({bus.out_bits, lo_q});

  link_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (req_in),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    in_bits_c = 12'h000;
    case (phase_q)
      PH_CAP0: in_bits_c = {frame_q.cpu_valid, frame_q.cpu_command, frame_q.cpu_wr_data};
      PH_CAP1: in_bits_c = frame_q.cpu_addr[11:0];
      PH_CAP2: in_bits_c = frame_q.cpu_addr[23:12];
      PH_HSK:  in_bits_c = {9'b0, hs_q};
      default: in_bits_c = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= PH_CAP0;
      frame_q     <= '0;
      hs_q        <= '0;
      lo_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      pad_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      phase_q     <= phase_d;
      rsp_valid_q <= 1'b0;
      case (phase_q)
        PH_CAP2:   hs_q <= {bus.mem_req_ready, bus.mem_resp_valid, bus.mem_resp_data};
        PH_OUT_LO: lo_q <= bus.out_bits;
        PH_OUT_HI: begin
          // Frame boundary: load the next frame (idle when nothing is queued) and retire the response.
          frame_q     <= empty ? link_req_t'('0) : head;
          rsp_q       <= rsp_word;
          rsp_valid_q <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 1'b1;
          if (rsp_word.pad != '0) pad_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready          = !full;
  assign bus.in_bits            = in_bits_c;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_cpu_ready      = rsp_q.cpu_ready;
  assign bus.rsp_cpu_read_valid = rsp_q.read_valid;
  assign bus.rsp_cpu_read_data  = rsp_q.read_data;
  assign bus.rsp_mem_req_valid  = rsp_q.mem_req_valid;
  assign bus.rsp_mem_req_rw     = rsp_q.mem_req_rw;
  assign bus.rsp_mem_req_addr   = rsp_q.mem_req_addr;
  assign bus.rsp_mem_req_data   = rsp_q.mem_req_data;
  assign bus.pad_err            = pad_err_q;
  assign bus.frame_cnt          = frame_cnt_q;
  assign bus.phase              = phase_q;
endmodule

// File: tb/tb_serial_link_host.sv
// Directed bench for serial_link_host: idle frames, one request, padding error,
// FIFO back-pressure ordering and mid-frame reset.
module tb_serial_link_host;
  import link_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  serial_link_host_if #(.CNT_W(16)) bus();

  serial_link_host #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic set_req(input logic [3:0] v, input logic [3:0] c, input logic [23:0] a,
                         input logic [3:0] w);
    bus.req_cpu_valid   = v;
    bus.req_cpu_command = c;
    bus.req_cpu_addr    = a;
    bus.req_cpu_wr_data = w;
  endtask

  task automatic wait_phase(input logic [2:0] p);
    for (int k = 0; k < 8 && bus.phase !== p; k++) @(negedge clk);
    n_cmp++;
    if (bus.phase !== p) begin
      n_err++;
      $display("FAIL wait_phase timeout: phase %0d, wanted %0d", bus.phase, p);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; set_req(4'h0, 4'h0, 24'h0, 4'h0);
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 1'b0;
    bus.out_bits = 12'h000;
    #12;
    n_cmp++; if (bus.phase !== 3'd0) begin n_err++; $display("FAIL rst_phase got %0d want 0", bus.phase); end
    n_cmp++; if (bus.in_bits !== 12'h000) begin n_err++; $display("FAIL rst_in_bits got %h want 000", bus.in_bits); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.pad_err !== 1'b0) begin n_err++; $display("FAIL rst_pad_err got %b want 0", bus.pad_err); end
    n_cmp++; if (bus.frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_frame_cnt got %0d want 0", bus.frame_cnt); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_cpu_ready !== 4'h0) begin n_err++; $display("FAIL rst_rsp_cpu_ready got %h want 0", bus.rsp_cpu_ready); end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      n_cmp++; if (bus.phase !== 3'(i % 6)) begin n_err++; $display("FAIL idle_phase cyc %0d got %0d want %0d", i, bus.phase, i % 6); end
      n_cmp++; if (bus.in_bits !== 12'h000) begin n_err++; $display("FAIL idle_in_bits cyc %0d got %h want 000", i, bus.in_bits); end
      n_cmp++; if (bus.rsp_valid !== ((i % 6 == 0) && i >= 6)) begin n_err++; $display("FAIL idle_rsp_valid cyc %0d got %b", i, bus.rsp_valid); end
      n_cmp++; if (bus.frame_cnt !== 16'(i / 6)) begin n_err++; $display("FAIL idle_frame_cnt cyc %0d got %0d want %0d", i, bus.frame_cnt, i / 6); end
      @(negedge clk);
    end
  endtask

  task automatic test_one_req();
    wait_phase(3'd0);
    set_req(4'b0001, 4'b0001, 24'hABC123, 4'b0001); bus.req_valid = 1'b1;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 1'b1;
    @(negedge clk); bus.req_valid = 1'b0;
    wait_phase(3'd0);
    n_cmp++; if (bus.in_bits !== 12'h111) begin n_err++; $display("FAIL one_req_ph0 got %h want 111", bus.in_bits); end
    @(negedge clk);
    n_cmp++; if (bus.in_bits !== 12'h123) begin n_err++; $display("FAIL one_req_ph1 got %h want 123", bus.in_bits); end
    @(negedge clk);
    n_cmp++; if (bus.in_bits !== 12'hABC) begin n_err++; $display("FAIL one_req_ph2 got %h want ABC", bus.in_bits); end
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.mem_resp_data = 1'b0;
    n_cmp++; if (bus.in_bits !== 12'h005) begin n_err++; $display("FAIL handshake_ph3 got %h want 005", bus.in_bits); end
    @(negedge clk); bus.out_bits = 12'h5A3;
    @(negedge clk); bus.out_bits = 12'h0F1;
    @(negedge clk); bus.out_bits = 12'h000;
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rsp_valid got %b want 1", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_cpu_ready !== 4'h7) begin n_err++; $display("FAIL rsp_cpu_ready got %h want 7", bus.rsp_cpu_ready); end
    n_cmp++; if (bus.rsp_cpu_read_valid !== 4'h8) begin n_err++; $display("FAIL rsp_read_valid got %h want 8", bus.rsp_cpu_read_valid); end
    n_cmp++; if (bus.rsp_cpu_read_data !== 4'hA) begin n_err++; $display("FAIL rsp_read_data got %h want A", bus.rsp_cpu_read_data); end
    n_cmp++; if (bus.rsp_mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rsp_mem_req_valid got %b want 1", bus.rsp_mem_req_valid); end
    n_cmp++; if (bus.rsp_mem_req_rw !== 1'b1) begin n_err++; $display("FAIL rsp_mem_req_rw got %b want 1", bus.rsp_mem_req_rw); end
    n_cmp++; if (bus.rsp_mem_req_addr !== 6'h11) begin n_err++; $display("FAIL rsp_mem_req_addr got %h want 11", bus.rsp_mem_req_addr); end
    n_cmp++; if (bus.rsp_mem_req_data !== 1'b1) begin n_err++; $display("FAIL rsp_mem_req_data got %b want 1", bus.rsp_mem_req_data); end
    n_cmp++; if (bus.pad_err !== 1'b0) begin n_err++; $display("FAIL pad_err_clean got %b want 0", bus.pad_err); end
    n_cmp++; if (bus.in_bits !== 12'h000) begin n_err++; $display("FAIL idle_after_req got %h want 000", bus.in_bits); end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_valid_pulse got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_cpu_ready !== 4'h7) begin n_err++; $display("FAIL rsp_hold got %h want 7", bus.rsp_cpu_ready); end
  endtask

  task automatic test_pad_err();
    wait_phase(3'd5); bus.out_bits = 12'hE00;
    @(negedge clk); bus.out_bits = 12'h000;
    n_cmp++; if (bus.pad_err !== 1'b1) begin n_err++; $display("FAIL pad_err_set got %b want 1", bus.pad_err); end
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL pad_rsp_valid got %b want 1", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_cpu_ready !== 4'h0) begin n_err++; $display("FAIL pad_cpu_ready got %h want 0", bus.rsp_cpu_ready); end
    @(negedge clk); wait_phase(3'd0);
    n_cmp++; if (bus.pad_err !== 1'b1) begin n_err++; $display("FAIL pad_err_sticky got %b want 1", bus.pad_err); end
    n_cmp++; if (bus.rsp_mem_req_valid !== 1'b0) begin n_err++; $display("FAIL pad_next_word got %b want 0", bus.rsp_mem_req_valid); end
  endtask

  task automatic test_back_to_back();
    wait_phase(3'd0);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_a got %b want 1", bus.req_ready); end
    set_req(4'h1, 4'h2, 24'h111222, 4'h3); bus.req_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_b got %b want 1", bus.req_ready); end
    set_req(4'h4, 4'h5, 24'h333444, 4'h6);
    @(negedge clk);
    set_req(4'h7, 4'h8, 24'h555666, 4'h9);
    for (int p = 2; p < 6; p++) begin
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full ph %0d got %b want 0", p, bus.req_ready); end
      @(negedge clk);
    end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_c got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.in_bits !== 12'h123) begin n_err++; $display("FAIL b2b_a_ph0 got %h want 123", bus.in_bits); end
    @(negedge clk); bus.req_valid = 1'b0;
    n_cmp++; if (bus.in_bits !== 12'h222) begin n_err++; $display("FAIL b2b_a_ph1 got %h want 222", bus.in_bits); end
    @(negedge clk);
    n_cmp++; if (bus.in_bits !== 12'h111) begin n_err++; $display("FAIL b2b_a_ph2 got %h want 111", bus.in_bits); end
    wait_phase(3'd0);
    n_cmp++; if (bus.in_bits !== 12'h456) begin n_err++; $display("FAIL b2b_b_ph0 got %h want 456", bus.in_bits); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (bus.in_bits !== 12'h333) begin n_err++; $display("FAIL b2b_b_ph2 got %h want 333", bus.in_bits); end
    wait_phase(3'd0);
    n_cmp++; if (bus.in_bits !== 12'h789) begin n_err++; $display("FAIL b2b_c_ph0 got %h want 789", bus.in_bits); end
    @(negedge clk); wait_phase(3'd0);
    n_cmp++; if (bus.in_bits !== 12'h000) begin n_err++; $display("FAIL b2b_idle got %h want 000", bus.in_bits); end
  endtask

  task automatic test_reset_mid();
    wait_phase(3'd0);
    set_req(4'hF, 4'h0, 24'hDEF012, 4'h0); bus.req_valid = 1'b1;
    @(negedge clk); bus.req_valid = 1'b0;
    wait_phase(3'd0);
    set_req(4'h2, 4'h2, 24'h222222, 4'h2); bus.req_valid = 1'b1;
    @(negedge clk);
    set_req(4'h3, 4'h3, 24'h333333, 4'h3);
    @(negedge clk); bus.req_valid = 1'b0;
    n_cmp++; if (bus.in_bits !== 12'hDEF) begin n_err++; $display("FAIL mid_pre_in_bits got %h want DEF", bus.in_bits); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL mid_pre_full got %b want 0", bus.req_ready); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_bits !== 12'h000) begin n_err++; $display("FAIL mid_in_bits got %h want 000", bus.in_bits); end
    n_cmp++; if (bus.phase !== 3'd0) begin n_err++; $display("FAIL mid_phase got %0d want 0", bus.phase); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.pad_err !== 1'b0) begin n_err++; $display("FAIL mid_pad_err got %b want 0", bus.pad_err); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid got %b want 0", bus.rsp_valid); end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (bus.in_bits !== 12'h000) begin n_err++; $display("FAIL post_rst_in_bits cyc %0d got %h want 000", i, bus.in_bits); end
      n_cmp++; if (bus.rsp_valid !== (i == 6)) begin n_err++; $display("FAIL post_rst_rsp_valid cyc %0d got %b", i, bus.rsp_valid); end
      n_cmp++; if (bus.frame_cnt !== 16'(i / 6)) begin n_err++; $display("FAIL post_rst_frame_cnt cyc %0d got %0d want %0d", i, bus.frame_cnt, i / 6); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_one_req();
    test_pad_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
